// File: rtl/rr_arbiter_8to3.sv
// Round-robin arbiter: 8 request lines, registered 3-bit grant index.
// Two-state FSM that holds each grant until the downstream handshake.
module rr_arbiter_8to3 #(
   parameter logic [2:0] PTR_INIT = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       grant_ready,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     r_state;
   logic [2:0] r_ptr;
   logic [2:0] r_grant_idx;
   logic       r_grant_valid;
   logic       r_busy;

   state_t     w_state_nxt;
   logic [2:0] w_ptr_nxt;
   logic [2:0] w_idx_nxt;
   logic       w_valid_nxt;
   logic       w_busy_nxt;

   logic [15:0] w_dbl;
   logic [7:0]  w_rot;
   logic [2:0]  w_off;
   logic [2:0]  w_sel;
   logic        w_any;

   // Rotate req so the pointer index lands at bit 0, then take the lowest set bit.
   always_comb begin
      w_dbl = {req, req};
      w_rot = w_dbl[7:0];
      for (int s = 0; s < 8; s++) begin
         if (r_ptr == 3'(s)) begin
            w_rot = w_dbl[s +: 8];
         end
      end
      w_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = 3'(i);
         end
      end
      w_sel = r_ptr + w_off;
      w_any = |req;
   end

   // Next-state and next-output decision for the IDLE/GRANT machine.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_grant_idx;
      w_valid_nxt = r_grant_valid;
      w_busy_nxt  = r_busy;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_idx_nxt   = w_sel;
               w_valid_nxt = 1'b1;
               w_busy_nxt  = 1'b1;
            end
         end
         GRANT: begin
            // req is ignored here; only the handshake releases the grant.
            if (r_grant_valid && grant_ready) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = r_grant_idx + 3'd1;
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, pointer and output registers; reset drops any pending grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_ptr         <= PTR_INIT;
         r_grant_idx   <= 3'd0;
         r_grant_valid <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_ptr         <= w_ptr_nxt;
         r_grant_idx   <= w_idx_nxt;
         r_grant_valid <= w_valid_nxt;
         r_busy        <= w_busy_nxt;
      end
   end

   assign grant_idx   = r_grant_idx;
   assign grant_valid = r_grant_valid;
   assign busy        = r_busy;

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// Directed bench for rr_arbiter_8to3 with immediate-assertion checks.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_arbiter_8to3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       grant_ready;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       busy;

   int checks = 0;
   int errors = 0;

   rr_arbiter_8to3 #(.PTR_INIT(3'd0)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant_ready (grant_ready),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] e_idx,
                          input logic e_valid, input logic e_busy);
      chk({tag, ".idx"},   8'(grant_idx),   8'(e_idx));
      chk({tag, ".valid"}, 8'(grant_valid), 8'(e_valid));
      chk({tag, ".busy"},  8'(busy),        8'(e_busy));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] dec;

   initial begin
      rst = 1'b1;
      req = 8'h00;
      grant_ready = 1'b0;
      #1;
      chk_out("reset", 3'd0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;

      // All requests high: 0..7,0 on alternate cycles.
      req = 8'hFF;
      grant_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         chk_out($sformatf("all_g%0d", k), 3'(k), 1'b1, 1'b1);
         dec = 8'h01 << grant_idx;
         chk($sformatf("dec_g%0d", k), dec, 8'h01 << (k % 8));
         if (k == 8) req = 8'h00;
         step();
         chk($sformatf("all_gap%0d.valid", k), 8'(grant_valid), 8'h00);
      end

      // Idle with no requests: nothing changes (ptr now 1).
      step();
      chk_out("idle_hold", 3'd0, 1'b0, 1'b0);

      // Bring ptr to 3 by granting 2, then 8'b1000_0100 picks 7.
      req = 8'h04;
      step();
      chk_out("pre2", 3'd2, 1'b1, 1'b1);
      req = 8'h84;
      step();
      chk_out("pre2_hs", 3'd2, 1'b0, 1'b0);
      step();
      chk_out("ptr3_g7", 3'd7, 1'b1, 1'b1);
      step();
      chk_out("ptr3_hs", 3'd7, 1'b0, 1'b0);
      step();
      chk_out("ptr0_g2", 3'd2, 1'b1, 1'b1);
      dec = 8'h01 << grant_idx;
      chk("dec_g2", dec, 8'h04);
      step();
      chk_out("ptr0_hs", 3'd2, 1'b0, 1'b0);

      // Grant 5 held through 4 stalled cycles while req drops.
      req = 8'h20;
      grant_ready = 1'b0;
      step();
      chk_out("g5", 3'd5, 1'b1, 1'b1);
      req = 8'h00;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_out($sformatf("g5_stall%0d", k), 3'd5, 1'b1, 1'b1);
      end
      grant_ready = 1'b1;
      step();
      chk_out("g5_hs", 3'd5, 1'b0, 1'b0);
      grant_ready = 1'b0;
      step();
      chk_out("g5_idle", 3'd5, 1'b0, 1'b0);

      // Pending grant at 6 dropped by asynchronous reset mid-cycle.
      req = 8'h40;
      step();
      chk_out("g6", 3'd6, 1'b1, 1'b1);
      req = 8'h00;
      #2;
      rst = 1'b1;
      #1;
      chk_out("g6_rst", 3'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      grant_ready = 1'b1;
      step();
      chk_out("post_rst1", 3'd0, 1'b0, 1'b0);
      step();
      chk_out("post_rst2", 3'd0, 1'b0, 1'b0);

      // Single request 7: wrap to 0 then 7 again 2 cycles later.
      req = 8'h80;
      step();
      chk_out("w7_a", 3'd7, 1'b1, 1'b1);
      step();
      chk_out("w7_hs", 3'd7, 1'b0, 1'b0);
      step();
      chk_out("w7_b", 3'd7, 1'b1, 1'b1);
      dec = 8'h01 << grant_idx;
      chk("dec_g7", dec, 8'h80);
      step();
      chk_out("w7_hs2", 3'd7, 1'b0, 1'b0);

      // After wrap ptr=0: 8'h81 must pick 0, not 7.
      req = 8'h81;
      step();
      chk_out("wrap_g0", 3'd0, 1'b1, 1'b1);
      step();
      chk_out("wrap_hs", 3'd0, 1'b0, 1'b0);
      step();
      chk_out("wrap_g7", 3'd7, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8to3.md
RR_ARBITER_8TO3 -- requirements
Module: rr_arbiter_8to3

Interface
REQ-001 SHALL have parameter: PTR_INIT, 3'd0, round-robin search start index loaded on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  8  request lines; bit i = requester i wants service.
REQ-005 SHALL have port: grant_idx  output  3  registered binary index of the granted requester, feeds the downstream 3-to-8 decoder.
REQ-006 SHALL have port: grant_valid  output  1  registered; grant_idx holds a live grant.
REQ-007 SHALL have port: grant_ready  input  1  downstream accepts the grant this cycle.
REQ-008 SHALL have port: busy  output  1  registered; high while the FSM is in GRANT.
REQ-009 SHALL state as decided: one clock; reset is asynchronous and active-high, ports named clk and rst.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011 SHALL hold a 3-bit pointer ptr: the first index searched for the next grant.
REQ-012 In IDLE with req != 0 at a rising edge, SHALL select the first set bit of req at index ptr, ptr+1, ... ptr+7 (mod 8).
REQ-013 On that edge, SHALL load grant_idx with the selected index, set grant_valid=1 and busy=1, and go to GRANT; latency is req sampled at edge N -> grant_valid high after edge N.
REQ-014 In IDLE with req == 0, SHALL stay in IDLE with grant_valid=0, and grant_idx and ptr unchanged.
REQ-015 In GRANT, SHALL hold grant_idx and grant_valid stable until a handshake, where a handshake is grant_valid & grant_ready at a rising edge.
REQ-016 In GRANT, SHALL ignore changes on req; deassertion of the granted req bit SHALL NOT retract the grant.
REQ-017 On a handshake, SHALL set ptr = grant_idx + 1 with 3-bit wrap (7 -> 0), clear grant_valid and busy, and return to IDLE.
REQ-018 After every handshake, SHALL spend at least one IDLE cycle before the next grant; the minimum grant-to-grant spacing is 2 cycles.
REQ-019 grant_ready while grant_valid=0 SHALL have no effect.
REQ-020 With all 8 requests held high, SHALL grant 0,1,...,7,0 in order, starting from PTR_INIT.
REQ-021 With a single request held high, SHALL grant it repeatedly, every 2 cycles while grant_ready=1.
REQ-022 SHALL contain no combinational path from req or grant_ready to any output.
REQ-023 SHALL never assert grant_valid for an index whose req bit was 0 at the selection edge.

Reset
REQ-024 On rst=1, SHALL immediately, without a clock edge, force grant_idx=3'd0, grant_valid=0, busy=0, state=IDLE, and ptr=PTR_INIT.
REQ-025 Reset asserted in GRANT SHALL drop the pending grant; it SHALL NOT be re-presented after reset.
REQ-026 On the first rising edge after rst falls, SHALL evaluate req normally per REQ-012.

Verification
REQ-027 SHALL verify: PTR_INIT=0, req=8'hFF, grant_ready=1 held -> grant_idx sequence 0,1,2,...,7,0 with grant_valid high on alternate cycles.
REQ-028 SHALL verify: req=8'b1000_0100, ptr=3 -> grant_idx=7; after handshake ptr=0 -> next grant_idx=2.
REQ-029 SHALL verify: grant to idx 5 with grant_ready=0 for 4 cycles while req goes to 8'h00 -> grant_idx=5 and grant_valid=1 stay stable; handshake on the 5th cycle -> IDLE, grant_valid=0.
REQ-030 SHALL verify: grant pending at idx 6, rst pulsed mid-cycle -> outputs go to 0/0/0 before the next edge; after release with req=8'h00, grant_valid stays 0.
REQ-031 SHALL verify: req=8'h80, grant_ready=1 -> grants idx 7, then ptr wraps to 0, then idx 7 again 2 cycles later.
REQ-032 SHALL verify: grant_idx driving the 3-to-8 decoder -> the decoded one-hot equals 1 << grant_idx whenever grant_valid=1.
